vc_allocator: RTL and testbench

Allocates downstream virtual channels to packets waiting at the head of the router's input buffers. It sits between the per-port input buffers and the switch allocator. It collects each input VC's head-flit request (`vc_request_o`) and the computed output port, and arbitrates per output port. It returns a one-cycle `vc_valid`/`vc_new` pair to the winning buffer, and it tracks ownership of every downstream VC until the owning input VC signals release (`vc_allocatable_o`).

---
 rtl/vc_allocator_pkg.sv | 28 ++
 rtl/round_robin_arbiter.sv | 83 ++++++++
 rtl/vc_allocator.sv | 164 ++++++++++++++++
 tb/tb_vc_allocator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Package     : noc_params
// Description : Router-wide sizes, output-port encoding and downstream VC
//               state type shared by the VC allocator and its arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_params;

    localparam int PORT_NUM = 5;
    localparam int VC_NUM   = 2;
    localparam int VC_SIZE  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    typedef enum logic {
        FREE      = 1'b0,
        ALLOCATED = 1'b1
    } vc_state_t;

endpackage
`default_nettype wire

// File: rtl/round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_arbiter
// Description : N-way one-hot arbiter. With VC_ALLOC_ROUND_ROBIN_EN defined it
//               rotates priority from a stored pointer advanced on update_i;
//               otherwise it is a lowest-index priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] request_i,
    input  logic         update_i,
    output logic [N-1:0] grant_o
);

`ifdef VC_ALLOC_ROUND_ROBIN_EN
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [N-1:0]  w_hi;
    logic [N-1:0]  w_lo;
    logic          w_hi_found;
    logic          w_lo_found;

    // First request at or above the pointer wins; otherwise wrap to the lowest.
    always_comb begin
        w_hi       = '0;
        w_lo       = '0;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (request_i[i] && !w_lo_found) begin
                w_lo[i]    = 1'b1;
                w_lo_found = 1'b1;
            end
            if (request_i[i] && !w_hi_found && (IW'(i) >= r_ptr)) begin
                w_hi[i]    = 1'b1;
                w_hi_found = 1'b1;
            end
        end
        grant_o = w_hi_found ? w_hi : w_lo;
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (grant_o[i]) begin
                w_ptr_nxt = (i == N - 1) ? '0 : IW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (update_i) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    logic w_found;
    logic w_unused;

    assign w_unused = &{1'b0, clk, rst, update_i};

    always_comb begin
        grant_o = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (request_i[i] && !w_found) begin
                grant_o[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/vc_allocator.sv
`default_nettype none
// ============================================================================
// Module      : vc_allocator
// Description : Per-output-port allocation of downstream VCs to head flits,
//               with ownership tracking until the owning input VC releases.
//               Arbitration is rotating when VC_ALLOC_ROUND_ROBIN_EN is
//               defined, fixed lowest-index priority otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_allocator
    import noc_params::*;
#(
    parameter int PORT_NUM = noc_params::PORT_NUM,
    parameter int VC_NUM   = noc_params::VC_NUM
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]          request_i,
    input  port_t [PORT_NUM-1:0][VC_NUM-1:0]          out_port_i,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]          release_i,
    output logic  [PORT_NUM-1:0][VC_NUM-1:0]          grant_o,
    output logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o
);

    localparam int N  = PORT_NUM * VC_NUM;
    localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int TW = $bits(port_t);

    vc_state_t                         r_state      [PORT_NUM][VC_NUM];
    logic [PW-1:0]                     r_owner_port [PORT_NUM][VC_NUM];
    logic [VC_SIZE-1:0]                r_owner_vc   [PORT_NUM][VC_NUM];
    logic [N-1:0]                      r_grant;
    logic [N-1:0][VC_SIZE-1:0]         r_vc_new;

    logic [N-1:0]                      w_req;
    logic [N-1:0]                      w_rel;
    logic [N-1:0][TW-1:0]              w_port;
    logic [N-1:0]                      w_owned;
    logic [N-1:0]                      w_elig;
    logic [PORT_NUM-1:0][VC_NUM-1:0]   w_rel_hit;
    logic [PORT_NUM-1:0]               w_has_free;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]  w_free_vc;
    logic [PORT_NUM-1:0][N-1:0]        w_arb_req;
    logic [PORT_NUM-1:0][N-1:0]        w_win;
    logic [PORT_NUM-1:0][PW-1:0]       w_win_port;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]  w_win_vc;
    logic [N-1:0]                      w_grant_nxt;
    logic [N-1:0][VC_SIZE-1:0]         w_vc_nxt;

    assign w_req    = request_i;
    assign w_rel    = release_i;
    assign w_port   = out_port_i;
    assign grant_o  = r_grant;
    assign vc_new_o = r_vc_new;

    // Which input VCs currently own something, and which downstream VCs see
    // their owner's release this cycle.
    always_comb begin
        w_owned   = '0;
        w_rel_hit = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                for (int p = 0; p < PORT_NUM; p++) begin
                    for (int c = 0; c < VC_NUM; c++) begin
                        if (r_state[o][v] == ALLOCATED &&
                            r_owner_port[o][v] == PW'(p) &&
                            r_owner_vc[o][v] == VC_SIZE'(c)) begin
                            w_owned[p*VC_NUM + c] = 1'b1;
                            w_rel_hit[o][v]       = w_rel[p*VC_NUM + c];
                        end
                    end
                end
            end
        end
    end

    // The in-flight grant masks the requester on the edge where the buffer
    // is still dropping its request.
    assign w_elig = w_req & ~r_grant & ~w_owned;

    always_comb begin
        w_has_free = '0;
        w_free_vc  = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int v = VC_NUM - 1; v >= 0; v--) begin
                if (r_state[o][v] == FREE) begin
                    w_has_free[o] = 1'b1;
                    w_free_vc[o]  = VC_SIZE'(v);
                end
            end
        end
    end

    always_comb begin
        w_arb_req = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < N; i++) begin
                w_arb_req[o][i] = w_has_free[o] && w_elig[i] && (w_port[i] == TW'(o));
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_arb
        round_robin_arbiter #(
            .N (N)
        ) u_arb (
            .clk       (clk),
            .rst       (rst),
            .request_i (w_arb_req[o]),
            .update_i  (|w_win[o]),
            .grant_o   (w_win[o])
        );
    end

    always_comb begin
        w_win_port  = '0;
        w_win_vc    = '0;
        w_grant_nxt = '0;
        w_vc_nxt    = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int c = 0; c < VC_NUM; c++) begin
                    if (w_win[o][p*VC_NUM + c]) begin
                        w_win_port[o]              = PW'(p);
                        w_win_vc[o]                = VC_SIZE'(c);
                        w_grant_nxt[p*VC_NUM + c]  = 1'b1;
                        w_vc_nxt[p*VC_NUM + c]     = w_free_vc[o];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant  <= '0;
            r_vc_new <= '0;
            for (int o = 0; o < PORT_NUM; o++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    r_state[o][v]      <= FREE;
                    r_owner_port[o][v] <= '0;
                    r_owner_vc[o][v]   <= '0;
                end
            end
        end else begin
            r_grant  <= w_grant_nxt;
            r_vc_new <= w_vc_nxt;
            for (int o = 0; o < PORT_NUM; o++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    if (w_rel_hit[o][v]) begin
                        r_state[o][v] <= FREE;
                    end
                end
                if (|w_win[o]) begin
                    r_state[o][w_free_vc[o]]      <= ALLOCATED;
                    r_owner_port[o][w_free_vc[o]] <= w_win_port[o];
                    r_owner_vc[o][w_free_vc[o]]   <= w_win_vc[o];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vc_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_allocator
// Description : Directed and random stimulus for vc_allocator, checked each
//               cycle against an ownership-table reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_allocator;
    import noc_params::*;

    localparam int P  = PORT_NUM;
    localparam int V  = VC_NUM;
    localparam int N  = P * V;
    localparam int VS = VC_SIZE;

    logic clk = 1'b0;
    logic rst;
    logic  [P-1:0][V-1:0]         req;
    logic  [P-1:0][V-1:0]         rel;
    port_t [P-1:0][V-1:0]         oport;
    logic  [P-1:0][V-1:0]         grant;
    logic  [P-1:0][V-1:0][VS-1:0] vc_new;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: owner flat index per downstream VC (-1 = free).
    int m_own   [P][V];
    int m_ptr   [P];
    bit m_grant [N];
    int m_vc    [N];

    vc_allocator #(
        .PORT_NUM (P),
        .VC_NUM   (V)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .request_i  (req),
        .out_port_i (oport),
        .release_i  (rel),
        .grant_o    (grant),
        .vc_new_o   (vc_new)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < P; o++) begin
            m_ptr[o] = 0;
            for (int v = 0; v < V; v++) m_own[o][v] = -1;
        end
        for (int k = 0; k < N; k++) begin
            m_grant[k] = 1'b0;
            m_vc[k]    = 0;
        end
    endtask

    task automatic model_step();
        bit owned [N];
        bit elig  [N];
        bit ng    [N];
        int nvc   [N];
        int nown  [P][V];
        int fv, win, idx, ow;
        for (int k = 0; k < N; k++) begin
            owned[k] = 1'b0;
            ng[k]    = 1'b0;
            nvc[k]   = 0;
        end
        for (int o = 0; o < P; o++)
            for (int v = 0; v < V; v++)
                if (m_own[o][v] >= 0) owned[m_own[o][v]] = 1'b1;
        for (int k = 0; k < N; k++)
            elig[k] = req[k / V][k % V] && !m_grant[k] && !owned[k];
        for (int o = 0; o < P; o++)
            for (int v = 0; v < V; v++) begin
                ow = m_own[o][v];
                nown[o][v] = (ow >= 0 && rel[ow / V][ow % V]) ? -1 : ow;
            end
        for (int o = 0; o < P; o++) begin
            fv  = -1;
            win = -1;
            for (int v = V - 1; v >= 0; v--)
                if (m_own[o][v] < 0) fv = v;
            if (fv >= 0) begin
                for (int k = 0; k < N; k++) begin
`ifdef VC_ALLOC_ROUND_ROBIN_EN
                    idx = (m_ptr[o] + k) % N;
`else
                    idx = k;
`endif
                    if (win < 0 && elig[idx] && int'(oport[idx / V][idx % V]) == o) win = idx;
                end
            end
            if (win >= 0) begin
                nown[o][fv] = win;
                ng[win]     = 1'b1;
                nvc[win]    = fv;
                m_ptr[o]    = (win + 1) % N;
            end
        end
        m_own   = nown;
        m_grant = ng;
        m_vc    = nvc;
    endtask

    task automatic step(input string tag);
        logic [63:0] eg, ev, ov;
        model_step();
        @(posedge clk);
        #1;
        eg = '0;
        ev = '0;
        ov = '0;
        for (int k = 0; k < N; k++) begin
            if (m_grant[k]) begin
                eg[k]            = 1'b1;
                ev[k*VS +: VS]   = VS'(m_vc[k]);
                ov[k*VS +: VS]   = vc_new[k / V][k % V];
            end
        end
        check({tag, "_grant"}, 64'(grant), eg);
        check({tag, "_vc"}, ov, ev);
    endtask

    task automatic rq(input int p, input int c, input bit on, input port_t d);
        req[p][c]   = on;
        oport[p][c] = d;
    endtask

    task automatic flush();
        req = '0;
        rel = '1;
        step("flush");
        rel = '0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        rel = '0;
        for (int p = 0; p < P; p++)
            for (int c = 0; c < V; c++) oport[p][c] = LOCAL;
        model_reset();
        #2;
        check("reset_grant", 64'(grant), 64'd0);
        check("reset_vc", 64'(vc_new), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single request, then no second grant once it drops.
        rq(0, 0, 1'b1, NORTH);
        step("t1a");
        check("t1_grant00", 64'(grant), 64'h1);
        check("t1_vc00", 64'(vc_new[0][0]), 64'd0);
        rq(0, 0, 1'b0, NORTH);
        step("t1b");
        check("t1_no_second", 64'(grant), 64'd0);
        flush();

        // Two WEST requesters fill it; a third waits for a release.
        rq(1, 0, 1'b1, WEST);
        rq(2, 1, 1'b1, WEST);
        step("t2a");
        check("t2a_grant", 64'(grant), 64'h4);
        check("t2a_vc", 64'(vc_new[1][0]), 64'd0);
        rq(1, 0, 1'b0, WEST);
        step("t2b");
        check("t2b_grant", 64'(grant), 64'h20);
        check("t2b_vc", 64'(vc_new[2][1]), 64'd1);
        rq(2, 1, 1'b0, WEST);
        rq(3, 0, 1'b1, WEST);
        step("t2c");
        check("t2c_full", 64'(grant), 64'd0);
        step("t2d");
        check("t2d_full", 64'(grant), 64'd0);
        rel[1][0] = 1'b1;
        step("t2e");
        check("t2e_same_cycle_release", 64'(grant), 64'd0);
        rel[1][0] = 1'b0;
        step("t2f");
        check("t2f_grant", 64'(grant), 64'h40);
        check("t2f_vc", 64'(vc_new[3][0]), 64'd0);
        rq(3, 0, 1'b0, WEST);
        flush();

        // Three EAST requesters re-requesting after release.
        rq(0, 0, 1'b1, EAST);
        rq(1, 0, 1'b1, EAST);
        rq(4, 1, 1'b1, EAST);
        step("t3a");
        check("t3a_grant", 64'(grant), 64'h1);
        rq(0, 0, 1'b0, EAST);
        rel[0][0] = 1'b1;
        step("t3b");
        check("t3b_grant", 64'(grant), 64'h4);
        check("t3b_vc", 64'(vc_new[1][0]), 64'd1);
        rel[0][0] = 1'b0;
        rq(0, 0, 1'b1, EAST);
        rq(1, 0, 1'b0, EAST);
        rel[1][0] = 1'b1;
        step("t3c");
`ifdef VC_ALLOC_ROUND_ROBIN_EN
        check("t3c_grant", 64'(grant), 64'h200);
        rel[1][0] = 1'b0;
        rq(4, 1, 1'b0, EAST);
        rel[4][1] = 1'b1;
        rq(1, 0, 1'b1, EAST);
        step("t3d");
        check("t3d_grant", 64'(grant), 64'h1);
`else
        check("t3c_grant", 64'(grant), 64'h1);
        rel[1][0] = 1'b0;
        rq(0, 0, 1'b0, EAST);
        rel[0][0] = 1'b1;
        rq(1, 0, 1'b1, EAST);
        step("t3d");
        check("t3d_grant", 64'(grant), 64'h4);
`endif
        rel = '0;
        flush();

        // Independent output ports grant in the same cycle.
        rq(0, 0, 1'b1, NORTH);
        rq(1, 0, 1'b1, SOUTH);
        step("t4");
        check("t4_parallel", 64'(grant), 64'h5);
        flush();

        // Asynchronous reset with two VCs allocated and a grant in flight.
        rq(0, 0, 1'b1, NORTH);
        step("t6a");
        rq(0, 0, 1'b0, NORTH);
        rq(1, 0, 1'b1, NORTH);
        step("t6b");
        check("t6b_vc", 64'(vc_new[1][0]), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_grant", 64'(grant), 64'd0);
        check("t6_async_vc", 64'(vc_new), 64'd0);
        model_reset();
        rq(1, 0, 1'b0, NORTH);
        rq(2, 0, 1'b1, NORTH);
        @(negedge clk);
        rst = 1'b0;
        step("t6c");
        check("t6c_grant", 64'(grant), 64'h10);
        check("t6c_vc", 64'(vc_new[2][0]), 64'd0);
        flush();

        // Random traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < P; p++) begin
                for (int c = 0; c < V; c++) begin
                    req[p][c]   = ($urandom_range(0, 2) == 0);
                    rel[p][c]   = ($urandom_range(0, 7) == 0);
                    oport[p][c] = port_t'($urandom_range(0, 4));
                end
            end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
